// File: rtl/src_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// src_ctrl_pkg
// Shared definitions for the SRC hardwired control sequencer:
//   - opcode encodings (5-bit field taken from the top of the IR)
//   - ALU operation select codes
//   - bit positions of every strobe inside the packed ctrl word
//   - sequencer state encoding (T0..T7 map directly onto the debug tstate value)
//   - strobe(): one-hot mask helper for a single ctrl bit
// -----------------------------------------------------------------------------
package src_ctrl_pkg;

    localparam int OPCODE_W = 5;

    // Opcode encodings
    localparam logic [OPCODE_W-1:0] OPC_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OPC_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OPC_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OPC_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OPC_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OPC_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OPC_BR   = 5'b10010;
    localparam logic [OPCODE_W-1:0] OPC_JR   = 5'b10011;
    localparam logic [OPCODE_W-1:0] OPC_JAL  = 5'b10100;
    localparam logic [OPCODE_W-1:0] OPC_IN   = 5'b10101;
    localparam logic [OPCODE_W-1:0] OPC_OUT  = 5'b10110;
    localparam logic [OPCODE_W-1:0] OPC_MFLO = 5'b10111;
    localparam logic [OPCODE_W-1:0] OPC_MFHI = 5'b11000;
    localparam logic [OPCODE_W-1:0] OPC_NOP  = 5'b11001;
    localparam logic [OPCODE_W-1:0] OPC_HALT = 5'b11010;

    // ALU operation select
    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0111;
    localparam logic [3:0] ALU_INCPC = 4'b1011;
    localparam logic [3:0] ALU_BRADD = 4'b1111;

    // Strobe bit positions inside ctrl
    localparam int CTRL_W      = 23;
    localparam int C_PCOUT     = 0;
    localparam int C_MARIN     = 1;
    localparam int C_ZLOWIN    = 2;
    localparam int C_ZLOWOUT   = 3;
    localparam int C_PCIN      = 4;
    localparam int C_MDRREAD   = 5;
    localparam int C_MDRIN     = 6;
    localparam int C_MDROUT    = 7;
    localparam int C_IRIN      = 8;
    localparam int C_GRA       = 9;
    localparam int C_GRB       = 10;
    localparam int C_GRC       = 11;
    localparam int C_RIN       = 12;
    localparam int C_ROUT      = 13;
    localparam int C_BAOUT     = 14;
    localparam int C_YIN       = 15;
    localparam int C_COUT      = 16;
    localparam int C_CONFFIN   = 17;
    localparam int C_WREN      = 18;
    localparam int C_OPIN      = 19;
    localparam int C_INPORTOUT = 20;
    localparam int C_HIOUT     = 21;
    localparam int C_LOOUT     = 22;

    // Sequencer states; T-steps equal their step number so tstate is the state itself
    typedef enum logic [3:0] {
        ST_T0     = 4'd0,
        ST_T1     = 4'd1,
        ST_T2     = 4'd2,
        ST_T3     = 4'd3,
        ST_T4     = 4'd4,
        ST_T5     = 4'd5,
        ST_T6     = 4'd6,
        ST_T7     = 4'd7,
        ST_RESET  = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

    // One-hot ctrl mask for a single strobe
    function automatic logic [CTRL_W-1:0] strobe(input int idx);
        return CTRL_W'(1'b1) << idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Pure combinational micro-step decode of (state, opcode, con_ff).
// Ports:
//   state      in   present sequencer state
//   opcode     in   instruction opcode (only meaningful from T3 on)
//   con_ff     in   branch condition, gates PCin in BR T6
//   ctrl       out  packed register/bus/ALU strobes
//   alu_sel    out  ALU operation select
//   last_step  out  present step is the final step of the instruction
//   mem_step   out  present step waits on mem_ready (MDRread or wren active)
//   halt_step  out  present step is the HALT opcode's execute step
//   illegal    out  T3 with an undefined opcode
// RESET and HALTED decode to all-zero strobes.
// -----------------------------------------------------------------------------
module ctrl_decode
    import src_ctrl_pkg::*;
(
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                con_ff,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [3:0]          alu_sel,
    output logic                last_step,
    output logic                mem_step,
    output logic                halt_step,
    output logic                illegal
);

    // Step/opcode decode into strobes and sequencing hints
    always_comb begin
        ctrl      = '0;
        alu_sel   = ALU_NOP;
        last_step = 1'b0;
        mem_step  = 1'b0;
        halt_step = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_T0: begin
                ctrl[C_PCOUT]  = 1'b1;
                ctrl[C_MARIN]  = 1'b1;
                ctrl[C_ZLOWIN] = 1'b1;
                alu_sel        = ALU_INCPC;
            end
            ST_T1: begin
                ctrl[C_ZLOWOUT] = 1'b1;
                ctrl[C_PCIN]    = 1'b1;
                ctrl[C_MDRREAD] = 1'b1;
                ctrl[C_MDRIN]   = 1'b1;
                mem_step        = 1'b1;
            end
            ST_T2: begin
                ctrl[C_MDROUT] = 1'b1;
                ctrl[C_IRIN]   = 1'b1;
            end
            ST_T3: begin
                case (opcode)
                    OPC_LD, OPC_LDI, OPC_ST: begin
                        ctrl[C_GRB]   = 1'b1;
                        ctrl[C_BAOUT] = 1'b1;
                        ctrl[C_YIN]   = 1'b1;
                    end
                    OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                        ctrl[C_GRB]  = 1'b1;
                        ctrl[C_ROUT] = 1'b1;
                        ctrl[C_YIN]  = 1'b1;
                    end
                    OPC_BR: begin
                        ctrl[C_GRA]     = 1'b1;
                        ctrl[C_ROUT]    = 1'b1;
                        ctrl[C_CONFFIN] = 1'b1;
                    end
                    OPC_JR: begin
                        ctrl[C_GRA]  = 1'b1;
                        ctrl[C_ROUT] = 1'b1;
                        ctrl[C_PCIN] = 1'b1;
                        last_step    = 1'b1;
                    end
                    OPC_JAL: begin
                        ctrl[C_GRB]   = 1'b1;
                        ctrl[C_RIN]   = 1'b1;
                        ctrl[C_PCOUT] = 1'b1;
                    end
                    OPC_IN: begin
                        ctrl[C_GRA]       = 1'b1;
                        ctrl[C_RIN]       = 1'b1;
                        ctrl[C_INPORTOUT] = 1'b1;
                        last_step         = 1'b1;
                    end
                    OPC_OUT: begin
                        ctrl[C_GRA]  = 1'b1;
                        ctrl[C_ROUT] = 1'b1;
                        ctrl[C_OPIN] = 1'b1;
                        last_step    = 1'b1;
                    end
                    OPC_MFLO: begin
                        ctrl[C_GRA]   = 1'b1;
                        ctrl[C_RIN]   = 1'b1;
                        ctrl[C_LOOUT] = 1'b1;
                        last_step     = 1'b1;
                    end
                    OPC_MFHI: begin
                        ctrl[C_GRA]   = 1'b1;
                        ctrl[C_RIN]   = 1'b1;
                        ctrl[C_HIOUT] = 1'b1;
                        last_step     = 1'b1;
                    end
                    OPC_NOP: begin
                        last_step = 1'b1;
                    end
                    OPC_HALT: begin
                        halt_step = 1'b1;
                    end
                    default: begin
                        // Undefined opcode behaves as NOP but is flagged
                        last_step = 1'b1;
                        illegal   = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI: begin
                        ctrl[C_COUT]   = 1'b1;
                        ctrl[C_ZLOWIN] = 1'b1;
                        alu_sel        = ALU_ADD;
                    end
                    OPC_ANDI: begin
                        ctrl[C_COUT]   = 1'b1;
                        ctrl[C_ZLOWIN] = 1'b1;
                        alu_sel        = ALU_AND;
                    end
                    OPC_ORI: begin
                        ctrl[C_COUT]   = 1'b1;
                        ctrl[C_ZLOWIN] = 1'b1;
                        alu_sel        = ALU_OR;
                    end
                    OPC_BR: begin
                        ctrl[C_PCOUT] = 1'b1;
                        ctrl[C_YIN]   = 1'b1;
                    end
                    OPC_JAL: begin
                        ctrl[C_GRA]  = 1'b1;
                        ctrl[C_ROUT] = 1'b1;
                        ctrl[C_PCIN] = 1'b1;
                        last_step    = 1'b1;
                    end
                    default: begin
                        // Unreachable for legal sequences; recover to T0
                        last_step = 1'b1;
                    end
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OPC_LD, OPC_ST: begin
                        ctrl[C_ZLOWOUT] = 1'b1;
                        ctrl[C_MARIN]   = 1'b1;
                    end
                    OPC_LDI, OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                        ctrl[C_ZLOWOUT] = 1'b1;
                        ctrl[C_GRA]     = 1'b1;
                        ctrl[C_RIN]     = 1'b1;
                        last_step       = 1'b1;
                    end
                    OPC_BR: begin
                        ctrl[C_COUT]   = 1'b1;
                        ctrl[C_ZLOWIN] = 1'b1;
                        alu_sel        = ALU_BRADD;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OPC_LD: begin
                        ctrl[C_MDRREAD] = 1'b1;
                        ctrl[C_MDRIN]   = 1'b1;
                        mem_step        = 1'b1;
                    end
                    OPC_ST: begin
                        ctrl[C_GRA]   = 1'b1;
                        ctrl[C_ROUT]  = 1'b1;
                        ctrl[C_MDRIN] = 1'b1;
                    end
                    OPC_BR: begin
                        // Branch target only loaded when the condition holds
                        ctrl[C_ZLOWOUT] = 1'b1;
                        ctrl[C_PCIN]    = con_ff;
                        last_step       = 1'b1;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OPC_LD: begin
                        ctrl[C_MDROUT] = 1'b1;
                        ctrl[C_GRA]    = 1'b1;
                        ctrl[C_RIN]    = 1'b1;
                        last_step      = 1'b1;
                    end
                    OPC_ST: begin
                        ctrl[C_WREN] = 1'b1;
                        mem_step     = 1'b1;
                        last_step    = 1'b1;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            default: begin
                // RESET / HALTED: no strobes
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired micro-step sequencer for the SRC datapath. Fetch T0-T2, execute
// T3-T7 per opcode, back to T0. Memory steps stall on mem_ready with an
// optional timeout that raises a sticky bus error and halts.
// Parameters: IR_W (IR width), OPC_W (opcode width, top of IR),
//             MEM_TIMEOUT (wait cycles before bus error, 0 = wait forever)
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ir                     instruction register
//   con_ff                 branch condition
//   mem_ready              memory completes this cycle
//   start / stop_req       leave HALTED / halt at next instruction boundary
//   step_mode, step        (CTRL_SINGLE_STEP_EN only) single-step control
//   ctrl, alu_sel          combinational strobes for the present step
//   tstate                 present state (debug)
//   running                sequencer active (not RESET/HALTED)
//   illegal_op             pulse during T3 of an undefined opcode
//   bus_err                sticky memory timeout flag
// Optional feature macro: CTRL_SINGLE_STEP_EN
// -----------------------------------------------------------------------------
module control_sequencer
    import src_ctrl_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   ir,
    input  logic              con_ff,
    input  logic              mem_ready,
    input  logic              start,
    input  logic              stop_req,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [CTRL_W-1:0] ctrl,
    output logic [3:0]        alu_sel,
    output logic [3:0]        tstate,
    output logic              running,
    output logic              illegal_op,
    output logic              bus_err
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic [CNT_W-1:0]      wait_cnt_nxt_s;
    logic [CNT_W-1:0]      wait_cnt_inc_s;
    logic                  bus_err_r;
    logic                  bus_err_nxt_s;
    logic                  adv_s;
    logic [OPCODE_W-1:0]   opcode_s;
    logic [CTRL_W-1:0]     dec_ctrl_s;
    logic [3:0]            dec_alu_s;
    logic                  dec_last_s;
    logic                  dec_mem_s;
    logic                  dec_halt_s;
    logic                  dec_illegal_s;
    logic                  unused_ir_s;

    assign opcode_s    = OPCODE_W'(ir[IR_W-1 -: OPC_W]);
    assign unused_ir_s = ^ir[IR_W-OPC_W-1:0];

    // Cycles in which the sequencer may act; outside them state holds and strobes are quiet
`ifdef CTRL_SINGLE_STEP_EN
    assign adv_s = ~step_mode | step;
`else
    assign adv_s = 1'b1;
`endif

    ctrl_decode u_decode (
        .state     (state_r),
        .opcode    (opcode_s),
        .con_ff    (con_ff),
        .ctrl      (dec_ctrl_s),
        .alu_sel   (dec_alu_s),
        .last_step (dec_last_s),
        .mem_step  (dec_mem_s),
        .halt_step (dec_halt_s),
        .illegal   (dec_illegal_s)
    );

    assign wait_cnt_inc_s = wait_cnt_r + CNT_W'(1'b1);

    // Next-state, wait counter and bus error update
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        bus_err_nxt_s  = bus_err_r;
        if (!adv_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_RESET: begin
                    state_nxt_s = ST_T0;
                end
                ST_HALTED: begin
                    if (start) begin
                        state_nxt_s = ST_T0;
                    end else begin
                        state_nxt_s = ST_HALTED;
                    end
                end
                default: begin
                    if (dec_mem_s && !mem_ready) begin
                        // Stall: hold state and strobes, count the wait
                        if ((MEM_TIMEOUT != 0) && (wait_cnt_inc_s == CNT_W'(MEM_TIMEOUT))) begin
                            bus_err_nxt_s  = 1'b1;
                            state_nxt_s    = ST_HALTED;
                            wait_cnt_nxt_s = '0;
                        end else begin
                            wait_cnt_nxt_s = wait_cnt_inc_s;
                        end
                    end else if (dec_halt_s) begin
                        state_nxt_s    = ST_HALTED;
                        wait_cnt_nxt_s = '0;
                    end else if (dec_last_s) begin
                        // Instruction boundary: the only place stop_req is honoured
                        if (stop_req) begin
                            state_nxt_s = ST_HALTED;
                        end else begin
                            state_nxt_s = ST_T0;
                        end
                        wait_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s    = state_t'(state_r + 4'd1);
                        wait_cnt_nxt_s = '0;
                    end
                end
            endcase
        end
    end

    // State, wait counter and sticky bus error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RESET;
            wait_cnt_r <= '0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            bus_err_r  <= bus_err_nxt_s;
        end
    end

    assign ctrl       = adv_s ? dec_ctrl_s : '0;
    assign alu_sel    = adv_s ? dec_alu_s : ALU_NOP;
    assign illegal_op = adv_s & dec_illegal_s;
    assign tstate     = state_r;
    assign running    = (state_r != ST_RESET) && (state_r != ST_HALTED);
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Table of per-cycle {inputs, expected outputs} records applied one per clock;
// each record is queued when driven and popped when the outputs are sampled
// mid-cycle. Hand-written sequences cover memory timeout, async reset in the
// middle of an instruction and (with CTRL_SINGLE_STEP_EN) single stepping.
// -----------------------------------------------------------------------------
module tb_control_sequencer;
    import src_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0]        opc;
        logic              con;
        logic              mr;
        logic              stop;
        logic              start;
        logic              smode;
        logic              stp;
        logic [3:0]        t;
        logic [CTRL_W-1:0] ctrl;
        logic [3:0]        alu;
        logic              run;
        logic              ill;
        logic              berr;
    } vec_t;

    localparam logic [3:0] TS_RESET = 4'd8;
    localparam logic [3:0] TS_HALT  = 4'd9;
    localparam logic [4:0] OPC_BAD  = 5'b11111;

    localparam logic [CTRL_W-1:0] M_T0   = strobe(C_PCOUT) | strobe(C_MARIN) | strobe(C_ZLOWIN);
    localparam logic [CTRL_W-1:0] M_T1   = strobe(C_ZLOWOUT) | strobe(C_PCIN) | strobe(C_MDRREAD) | strobe(C_MDRIN);
    localparam logic [CTRL_W-1:0] M_T2   = strobe(C_MDROUT) | strobe(C_IRIN);
    localparam logic [CTRL_W-1:0] M_LD3  = strobe(C_GRB) | strobe(C_BAOUT) | strobe(C_YIN);
    localparam logic [CTRL_W-1:0] M_AD4  = strobe(C_COUT) | strobe(C_ZLOWIN);
    localparam logic [CTRL_W-1:0] M_LD5  = strobe(C_ZLOWOUT) | strobe(C_MARIN);
    localparam logic [CTRL_W-1:0] M_LD6  = strobe(C_MDRREAD) | strobe(C_MDRIN);
    localparam logic [CTRL_W-1:0] M_LD7  = strobe(C_MDROUT) | strobe(C_GRA) | strobe(C_RIN);
    localparam logic [CTRL_W-1:0] M_WB   = strobe(C_ZLOWOUT) | strobe(C_GRA) | strobe(C_RIN);
    localparam logic [CTRL_W-1:0] M_IM3  = strobe(C_GRB) | strobe(C_ROUT) | strobe(C_YIN);
    localparam logic [CTRL_W-1:0] M_BR3  = strobe(C_GRA) | strobe(C_ROUT) | strobe(C_CONFFIN);
    localparam logic [CTRL_W-1:0] M_BR4  = strobe(C_PCOUT) | strobe(C_YIN);
    localparam logic [CTRL_W-1:0] M_BR6  = strobe(C_ZLOWOUT);
    localparam logic [CTRL_W-1:0] M_BR6T = strobe(C_ZLOWOUT) | strobe(C_PCIN);
    localparam logic [CTRL_W-1:0] M_ST6  = strobe(C_GRA) | strobe(C_ROUT) | strobe(C_MDRIN);
    localparam logic [CTRL_W-1:0] M_ST7  = strobe(C_WREN);
    localparam logic [CTRL_W-1:0] M_JAL3 = strobe(C_GRB) | strobe(C_RIN) | strobe(C_PCOUT);
    localparam logic [CTRL_W-1:0] M_JAL4 = strobe(C_GRA) | strobe(C_ROUT) | strobe(C_PCIN);
    localparam logic [CTRL_W-1:0] M_OUT3 = strobe(C_GRA) | strobe(C_ROUT) | strobe(C_OPIN);
    localparam logic [CTRL_W-1:0] M_ZERO = '0;

    logic              clk;
    logic              rst_n;
    logic [31:0]       ir;
    logic              con_ff;
    logic              mem_ready;
    logic              start;
    logic              stop_req;
    logic [CTRL_W-1:0] ctrl;
    logic [3:0]        alu_sel;
    logic [3:0]        tstate;
    logic              running;
    logic              illegal_op;
    logic              bus_err;
`ifdef CTRL_SINGLE_STEP_EN
    logic              step_mode;
    logic              step;
`endif

    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    vec_t exp_q[$];

    control_sequencer #(
        .IR_W        (32),
        .OPC_W       (5),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .con_ff     (con_ff),
        .mem_ready  (mem_ready),
        .start      (start),
        .stop_req   (stop_req),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step       (step),
`endif
        .ctrl       (ctrl),
        .alu_sel    (alu_sel),
        .tstate     (tstate),
        .running    (running),
        .illegal_op (illegal_op),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [4:0] opc, input logic con, input logic mr,
                                 input logic stop, input logic st, input logic [3:0] t,
                                 input logic [CTRL_W-1:0] c, input logic [3:0] alu,
                                 input logic ill, input logic berr);
        vec_t v;
        v.opc   = opc;
        v.con   = con;
        v.mr    = mr;
        v.stop  = stop;
        v.start = st;
        v.smode = 1'b0;
        v.stp   = 1'b0;
        v.t     = t;
        v.ctrl  = c;
        v.alu   = alu;
        v.run   = (t <= 4'd7);
        v.ill   = ill;
        v.berr  = berr;
        return v;
    endfunction

    task automatic add(input logic [4:0] opc, input logic con, input logic mr, input logic stop,
                       input logic st, input logic [3:0] t, input logic [CTRL_W-1:0] c,
                       input logic [3:0] alu, input logic ill);
        tbl.push_back(mkv(opc, con, mr, stop, st, t, c, alu, ill, 1'b0));
    endtask

    task automatic add_fetch(input logic [4:0] opc, input logic con);
        add(opc, con, 1'b1, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0);
        add(opc, con, 1'b1, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0);
        add(opc, con, 1'b1, 1'b0, 1'b0, 4'd2, M_T2, ALU_NOP, 1'b0);
    endtask

    task automatic check_out(input string name);
        vec_t        e;
        logic [33:0] act;
        logic [33:0] exp;
        e   = exp_q.pop_front();
        act = {tstate, ctrl, alu_sel, running, illegal_op, bus_err};
        exp = {e.t, e.ctrl, e.alu, e.run, e.ill, e.berr};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got t=%0d ctrl=%h alu=%h run=%b ill=%b berr=%b, expected t=%0d ctrl=%h alu=%h run=%b ill=%b berr=%b",
                     name, tstate, ctrl, alu_sel, running, illegal_op, bus_err,
                     e.t, e.ctrl, e.alu, e.run, e.ill, e.berr);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        ir        = {v.opc, 27'd0};
        con_ff    = v.con;
        mem_ready = v.mr;
        stop_req  = v.stop;
        start     = v.start;
`ifdef CTRL_SINGLE_STEP_EN
        step_mode = v.smode;
        step      = v.stp;
`endif
        exp_q.push_back(v);
        #1;
        check_out(name);
    endtask

    initial begin
        vec_t v;
        n_cmp     = 0;
        n_bad     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        ir        = 32'd0;
        con_ff    = 1'b0;
        mem_ready = 1'b1;
        start     = 1'b0;
        stop_req  = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif

        // LD with memory always ready
        add_fetch(OPC_LD, 1'b0);
        add(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_LD3, ALU_NOP, 1'b0);
        add(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_ADD, 1'b0);
        add(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_LD5, ALU_NOP, 1'b0);
        add(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, M_LD6, ALU_NOP, 1'b0);
        add(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, M_LD7, ALU_NOP, 1'b0);
        // BR not taken, then taken
        for (int k = 0; k < 2; k++) begin
            add_fetch(OPC_BR, k[0]);
            add(OPC_BR, k[0], 1'b1, 1'b0, 1'b0, 4'd3, M_BR3, ALU_NOP, 1'b0);
            add(OPC_BR, k[0], 1'b1, 1'b0, 1'b0, 4'd4, M_BR4, ALU_NOP, 1'b0);
            add(OPC_BR, k[0], 1'b1, 1'b0, 1'b0, 4'd5, M_AD4, ALU_BRADD, 1'b0);
            add(OPC_BR, k[0], 1'b1, 1'b0, 1'b0, 4'd6, (k == 0) ? M_BR6 : M_BR6T, ALU_NOP, 1'b0);
        end
        // NOP with a 3-cycle fetch stall
        add(OPC_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0);
        for (int k = 0; k < 3; k++) begin
            add(OPC_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0);
        end
        add(OPC_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0);
        add(OPC_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_T2, ALU_NOP, 1'b0);
        add(OPC_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_ZERO, ALU_NOP, 1'b0);
        // ST with one write stall in T7
        add_fetch(OPC_ST, 1'b0);
        add(OPC_ST, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_LD3, ALU_NOP, 1'b0);
        add(OPC_ST, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_ADD, 1'b0);
        add(OPC_ST, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_LD5, ALU_NOP, 1'b0);
        add(OPC_ST, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, M_ST6, ALU_NOP, 1'b0);
        add(OPC_ST, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, M_ST7, ALU_NOP, 1'b0);
        add(OPC_ST, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, M_ST7, ALU_NOP, 1'b0);
        // ANDI
        add_fetch(OPC_ANDI, 1'b0);
        add(OPC_ANDI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_IM3, ALU_NOP, 1'b0);
        add(OPC_ANDI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_AND, 1'b0);
        add(OPC_ANDI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_WB, ALU_NOP, 1'b0);
        // JAL, OUT
        add_fetch(OPC_JAL, 1'b0);
        add(OPC_JAL, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_JAL3, ALU_NOP, 1'b0);
        add(OPC_JAL, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_JAL4, ALU_NOP, 1'b0);
        add_fetch(OPC_OUT, 1'b0);
        add(OPC_OUT, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_OUT3, ALU_NOP, 1'b0);
        // ADDI: stop_req ignored in T3, honoured at T5
        add_fetch(OPC_ADDI, 1'b0);
        add(OPC_ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, M_IM3, ALU_NOP, 1'b0);
        add(OPC_ADDI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_ADD, 1'b0);
        add(OPC_ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, M_WB, ALU_NOP, 1'b0);
        add(OPC_ADDI, 1'b0, 1'b1, 1'b0, 1'b0, TS_HALT, M_ZERO, ALU_NOP, 1'b0);
        add(OPC_ADDI, 1'b0, 1'b1, 1'b0, 1'b1, TS_HALT, M_ZERO, ALU_NOP, 1'b0);
        // Undefined opcode: NOP plus illegal pulse
        add_fetch(OPC_BAD, 1'b0);
        add(OPC_BAD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_ZERO, ALU_NOP, 1'b1);
        // HALT, restart
        add_fetch(OPC_HALT, 1'b0);
        add(OPC_HALT, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_ZERO, ALU_NOP, 1'b0);
        add(OPC_HALT, 1'b0, 1'b1, 1'b0, 1'b1, TS_HALT, M_ZERO, ALU_NOP, 1'b0);
        // ORI with start asserted while running (ignored)
        add_fetch(OPC_ORI, 1'b0);
        add(OPC_ORI, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, M_IM3, ALU_NOP, 1'b0);
        add(OPC_ORI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_OR, 1'b0);
        add(OPC_ORI, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_WB, ALU_NOP, 1'b0);

        // Reset state, then release
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, TS_RESET, M_ZERO, ALU_NOP, 1'b0, 1'b0), "reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Memory timeout in fetch: 15 wait cycles then HALTED with bus_err
        apply(mkv(OPC_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0, 1'b0), "to_t0");
        for (int k = 0; k < 15; k++) begin
            apply(mkv(OPC_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0, 1'b0),
                  $sformatf("to_wait%0d", k));
        end
        apply(mkv(OPC_NOP, 1'b0, 1'b0, 1'b0, 1'b0, TS_HALT, M_ZERO, ALU_NOP, 1'b0, 1'b1), "to_halt");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b1, TS_HALT, M_ZERO, ALU_NOP, 1'b0, 1'b1), "to_start");

        // LD interrupted by reset in T5; bus_err still sticky until then
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0, 1'b1), "rs_t0");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0, 1'b1), "rs_t1");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_T2, ALU_NOP, 1'b0, 1'b1), "rs_t2");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_LD3, ALU_NOP, 1'b0, 1'b1), "rs_t3");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_ADD, 1'b0, 1'b1), "rs_t4");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_LD5, ALU_NOP, 1'b0, 1'b1), "rs_t5");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, TS_RESET, M_ZERO, ALU_NOP, 1'b0, 1'b0));
        check_out("rs_async");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, TS_RESET, M_ZERO, ALU_NOP, 1'b0, 1'b0), "rs_hold");
        rst_n = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
        // Single step: one step per pulse of step, every 4th clock
        for (int k = 0; k < 12; k++) begin
            logic [CTRL_W-1:0] m;
            logic [3:0]        a;
            m = M_ZERO;
            a = ALU_NOP;
            if ((k % 4) == 3) begin
                m = (k / 4 == 0) ? M_T0 : ((k / 4 == 1) ? M_T1 : M_T2);
                a = (k / 4 == 0) ? ALU_INCPC : ALU_NOP;
            end
            v       = mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k / 4), m, a, 1'b0, 1'b0);
            v.smode = 1'b1;
            v.stp   = ((k % 4) == 3);
            apply(v, $sformatf("ss%0d", k));
        end
`else
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0, 1'b0), "ld_t0");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, M_T1, ALU_NOP, 1'b0, 1'b0), "ld_t1");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_T2, ALU_NOP, 1'b0, 1'b0), "ld_t2");
`endif
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, M_LD3, ALU_NOP, 1'b0, 1'b0), "ld_t3");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, M_AD4, ALU_ADD, 1'b0, 1'b0), "ld_t4");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, M_LD5, ALU_NOP, 1'b0, 1'b0), "ld_t5");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, M_LD6, ALU_NOP, 1'b0, 1'b0), "ld_t6");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, M_LD7, ALU_NOP, 1'b0, 1'b0), "ld_t7");
        apply(mkv(OPC_LD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, M_T0, ALU_INCPC, 1'b0, 1'b0), "ld_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
